// File: rtl/spw_tick_gen.sv
// Periodic SpaceWire time-code source: counts rising edges of the divided slow clock
// and raises a held tick request every tick_period edges, flagging ticks that arrive while busy.
module spw_tick_gen #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned MISS_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                slow_clk_in,
    input  logic                enable,
    input  logic                link_running,
    input  logic [PERIOD_W-1:0] tick_period,
    input  logic [1:0]          ctrl_flags,
    input  logic                tick_ack,
    output logic                tick_req,
    output logic [5:0]          time_out,
    output logic [1:0]          ctrl_out,
    output logic                tick_missed,
    output logic [MISS_W-1:0]   miss_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
    localparam logic [MISS_W-1:0]   MISS_ONE   = MISS_W'(1);

    logic [0:0]          state;
    logic                slow_prev;
    logic [PERIOD_W-1:0] edge_cnt;
    logic [PERIOD_W-1:0] cnt_limit;
    logic                slow_edge;
    logic                active;
    logic                tick_event;

    // A zero period behaves like a period of one, so the wrap limit is clamped at 0.
    always_comb begin
        slow_edge  = slow_clk_in & ~slow_prev;
        active     = enable & link_running;
        cnt_limit  = (tick_period == '0) ? '0 : (tick_period - PERIOD_ONE);
        tick_event = active & slow_edge & (edge_cnt >= cnt_limit);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slow_prev <= 1'b0;
        end else begin
            slow_prev <= slow_clk_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_cnt <= '0;
        end else if (!active) begin
            edge_cnt <= '0;
        end else if (slow_edge) begin
            if (edge_cnt >= cnt_limit) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PERIOD_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            tick_req    <= 1'b0;
            time_out    <= '0;
            ctrl_out    <= '0;
            tick_missed <= 1'b0;
            miss_count  <= '0;
        end else begin
            tick_missed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick_event) begin
                        time_out <= time_out + 6'd1;
                        ctrl_out <= ctrl_flags;
                        tick_req <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Losing the gate wins over any ack/event pending in the same cycle.
                    if (!active) begin
                        tick_req <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (tick_event && tick_ack) begin
                        time_out <= time_out + 6'd1;
                        ctrl_out <= ctrl_flags;
                        tick_req <= 1'b1;
                    end else if (tick_event) begin
                        tick_missed <= 1'b1;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + MISS_ONE;
                        end
                    end else if (tick_ack) begin
                        tick_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    tick_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spw_tick_gen.sv
// Scoreboard bench for spw_tick_gen: directed slow-clock patterns push expected time-codes,
// a negedge monitor pops them whenever a new time-code or miss pulse appears.
module tb_spw_tick_gen;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned MISS_W   = 8;

    logic                clk;
    logic                reset_n;
    logic                slow_clk_in;
    logic                enable;
    logic                link_running;
    logic [PERIOD_W-1:0] tick_period;
    logic [1:0]          ctrl_flags;
    logic                tick_ack;
    logic                tick_req;
    logic [5:0]          time_out;
    logic [1:0]          ctrl_out;
    logic                tick_missed;
    logic [MISS_W-1:0]   miss_count;

    spw_tick_gen #(
        .PERIOD_W(PERIOD_W),
        .MISS_W  (MISS_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .slow_clk_in (slow_clk_in),
        .enable      (enable),
        .link_running(link_running),
        .tick_period (tick_period),
        .ctrl_flags  (ctrl_flags),
        .tick_ack    (tick_ack),
        .tick_req    (tick_req),
        .time_out    (time_out),
        .ctrl_out    (ctrl_out),
        .tick_missed (tick_missed),
        .miss_count  (miss_count)
    );

    typedef struct {
        int unsigned tval;
        int unsigned cval;
        int unsigned gap;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned miss_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;
    int unsigned cycle  = 0;
    int unsigned last_rise = 0;
    logic        prev_req  = 1'b0;
    logic [5:0]  prev_time = '0;
    logic        auto_ack  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void check(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Monitor: a rising tick_req or a time change while held marks a new time-code.
    always @(negedge clk) begin
        exp_t e;
        int unsigned m;
        if (reset_n) begin
            if (tick_req && (!prev_req || time_out != prev_time)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_tick: got time %0d expected none (cycle %0d)", time_out, cycle);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_time", time_out, e.tval);
                    check("tick_ctrl", ctrl_out, e.cval);
                    if (e.gap != 0) check("tick_gap", cycle - last_rise, e.gap);
                end
                if (!prev_req) last_rise = cycle;
            end
            if (tick_missed) begin
                if (miss_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_miss: got miss_count %0d expected no pulse (cycle %0d)", miss_count, cycle);
                end else begin
                    m = miss_q.pop_front();
                    check("miss_count_at_pulse", miss_count, m);
                end
            end
        end
        prev_req  = tick_req;
        prev_time = time_out;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_ack) tick_ack = tick_req & ~tick_ack;
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc();
    endtask

    task automatic slow_pulse(input int unsigned hi, input int unsigned lo);
        slow_clk_in = 1'b1;
        cycles(hi);
        slow_clk_in = 1'b0;
        cycles(lo);
    endtask

    task automatic push_tick(input int unsigned t, input int unsigned c, input int unsigned gap);
        exp_t e;
        e.tval = t;
        e.cval = c;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        slow_clk_in  = 1'b0;
        enable       = 1'b1;
        link_running = 1'b1;
        tick_period  = 16'd3;
        ctrl_flags   = 2'b10;
        tick_ack     = 1'b0;
        cycles(3);
        check("rst_tick_req", tick_req, 0);
        check("rst_time_out", time_out, 0);
        check("rst_ctrl_out", ctrl_out, 0);
        check("rst_tick_missed", tick_missed, 0);
        check("rst_miss_count", miss_count, 0);
        reset_n = 1'b1;

        // Divider-style slow clock, 51 clk per period, tick every 3 edges.
        auto_ack = 1'b1;
        push_tick(1, 2'b10, 0);
        push_tick(2, 2'b01, 153);
        push_tick(3, 2'b11, 153);
        for (int unsigned k = 0; k < 9; k++) begin
            if (k == 3) ctrl_flags = 2'b01;
            if (k == 6) ctrl_flags = 2'b11;
            slow_pulse(25, 26);
        end
        check("t1_time_out", time_out, 3);

        // 64 acknowledged ticks, period 1: wraps 63 -> 0.
        tick_period = 16'd1;
        ctrl_flags  = 2'b01;
        for (int unsigned i = 0; i < 64; i++) begin
            push_tick((4 + i) % 64, 2'b01, (i == 0) ? 0 : 4);
            slow_pulse(2, 2);
        end
        check("t2_time_out", time_out, 3);
        check("t2_miss_count", miss_count, 0);

        // Ack coincides with a new event: new code, no miss.
        auto_ack = 1'b0;
        cycles(2);
        tick_ack = 1'b0;
        push_tick(4, 2'b01, 0);
        slow_pulse(2, 2);
        ctrl_flags = 2'b11;
        push_tick(5, 2'b11, 0);
        slow_clk_in = 1'b1;
        tick_ack    = 1'b1;
        cyc();
        tick_ack = 1'b0;
        check("t4_tick_req", tick_req, 1);
        check("t4_time_out", time_out, 5);
        check("t4_tick_missed", tick_missed, 0);
        cyc();
        slow_clk_in = 1'b0;
        cycles(2);
        tick_ack = 1'b1;
        cyc();
        tick_ack = 1'b0;
        check("t4_ack_release", tick_req, 0);

        // Link drop mid-request clears the request and the edge counter.
        tick_period = 16'd3;
        push_tick(6, 2'b11, 0);
        for (int unsigned i = 0; i < 3; i++) slow_pulse(2, 2);
        check("t6_req_up", tick_req, 1);
        slow_pulse(2, 2);
        link_running = 1'b0;
        cyc();
        check("t6_req_drop", tick_req, 0);
        check("t6_edge_cnt", dut.edge_cnt, 0);
        check("t6_time_kept", time_out, 6);
        link_running = 1'b1;
        cyc();
        slow_pulse(2, 2);
        slow_pulse(2, 2);
        check("t6_no_early_tick", tick_req, 0);
        push_tick(7, 2'b11, 0);
        slow_pulse(2, 2);
        check("t6_tick_after_restore", tick_req, 1);
        check("t6_time_continue", time_out, 7);

        // Period 0 behaves as 1.
        auto_ack = 1'b1;
        cycles(3);
        tick_period = 16'd0;
        ctrl_flags  = 2'b00;
        push_tick(8, 2'b00, 0);
        push_tick(9, 2'b00, 4);
        push_tick(10, 2'b00, 4);
        for (int unsigned i = 0; i < 3; i++) slow_pulse(2, 2);
        check("t7_time_out", time_out, 10);
        check("t7_miss_count", miss_count, 0);

        // Reset for one cycle in the middle of a request.
        auto_ack = 1'b0;
        cycles(2);
        tick_ack    = 1'b0;
        ctrl_flags  = 2'b10;
        tick_period = 16'd1;
        push_tick(11, 2'b10, 0);
        slow_pulse(2, 2);
        check("t5_req_before_reset", tick_req, 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        check("t5_tick_req", tick_req, 0);
        check("t5_time_out", time_out, 0);
        check("t5_ctrl_out", ctrl_out, 0);
        check("t5_tick_missed", tick_missed, 0);
        check("t5_miss_count", miss_count, 0);

        // Ack withheld across two events: two misses, request held.
        push_tick(1, 2'b10, 0);
        slow_pulse(2, 2);
        miss_q.push_back(1);
        slow_pulse(2, 2);
        miss_q.push_back(2);
        slow_pulse(2, 2);
        check("t3_time_out", time_out, 1);
        check("t3_tick_req", tick_req, 1);
        check("t3_miss_count", miss_count, 2);
        tick_ack = 1'b1;
        cyc();
        tick_ack = 1'b0;
        check("t3_ack_release", tick_req, 0);
        cycles(4);
        check("t3_miss_count_kept", miss_count, 2);

        check("exp_q_drained", exp_q.size(), 0);
        check("miss_q_drained", miss_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/spw_tick_gen.md
Name: spw_tick_gen

Overview:
- Periodic SpaceWire time-code source for the debug/bring-up path.
- Consumes the divided slow clock (clk_reduced, generated in the clk domain) as a timebase and counts its rising edges.
- Every tick_period edges, raises a held tick request carrying a 6-bit time value and 2 control flags toward the transmitter's tick_in/time_in interface.
- Holds each request until it is acknowledged, and flags any tick that occurs while a request is still pending.

Parameters:
PERIOD_W, 16, width of the tick_period input and the edge counter
MISS_W, 8, width of the saturating missed-tick counter

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
slow_clk_in  input  1  divided clock level from the clock divider, synchronous to clk
enable  input  1  tick generation enable
link_running  input  1  SpaceWire link in Run state
tick_period  input  PERIOD_W  slow-clock rising edges per tick; 0 is treated as 1
ctrl_flags  input  2  control flags captured into each new time-code
tick_ack  input  1  transmitter accepted the current time-code
tick_req  output  1  time-code request, held until acknowledged
time_out  output  6  time value of the current/last time-code
ctrl_out  output  2  control flags of the current/last time-code
tick_missed  output  1  one-cycle pulse: tick event dropped
miss_count  output  MISS_W  saturating count of dropped ticks

Behaviour:
- Reset: clk and reset_n only; reset_n is synchronous, active-low, sampled on posedge clk.
- Reset values: tick_req=0, time_out=0, ctrl_out=0, tick_missed=0, miss_count=0; internal edge counter=0; slow_prev=0; state=IDLE.
- Reset mid-request drops the request with no further handshake.
- Edge detect: slow_prev <= slow_clk_in each cycle. edge = slow_clk_in & ~slow_prev. Latency is one clk from the level change.
- The divider drives 1 in the first cycle after its reset, so an edge is seen immediately.
- Gate: active = enable & link_running. When active=0, the edge counter clears to 0 and no events are generated.
- Edge counter: on edge with active=1:
  - if cnt >= eff_period-1 (eff_period = max(tick_period,1)), then cnt <= 0 and event=1;
  - else cnt <= cnt+1.
- tick_period is compared live. Lowering it below cnt fires on the next edge.
- State machine, IDLE:
  - event -> time_out <= time_out+1 (mod 64, 63 wraps to 0), ctrl_out <= ctrl_flags, tick_req <= 1, go to REQ.
  - tick_ack is ignored.
- State machine, REQ: tick_req, time_out and ctrl_out are held stable.
  - tick_ack=1, no event -> tick_req <= 0, go to IDLE.
  - tick_ack=1 and event in the same cycle -> new time-code immediately: time_out increments, ctrl_out recaptured, tick_req stays 1, stay in REQ, no miss.
  - event, tick_ack=0 -> tick_missed=1 for one cycle, miss_count increments (saturates at all-ones), time_out unchanged, request stays.
  - active falls -> tick_req <= 0, go to IDLE, time_out/ctrl_out retained, no miss flagged.
- The first time-code after reset carries time 1.
- miss_count clears only on reset.
- Output latency: tick_req rises one clk after the cycle in which edge is detected.

Test Plan:
- Divider-style slow clock (25 high / 26 low), tick_period=3, enable=link_running=1, tick_ack one cycle after tick_req -> tick_req every 153 clk; time_out 1,2,3; ctrl_out = ctrl_flags at capture.
- 64 acknowledged ticks, tick_period=1 -> time_out 63 followed by 0; no tick_missed; miss_count=0.
- tick_ack withheld across 2 events -> two tick_missed pulses; miss_count=2; time_out stays 1; tick_req held. Then ack -> tick_req=0.
- tick_ack asserted in the same cycle as an event -> tick_req stays 1; time_out 1->2; tick_missed=0.
- link_running dropped while tick_req=1 -> tick_req=0 next cycle, edge counter 0. Restore link -> first tick after tick_period edges with time_out continuing.
- reset_n low for one cycle mid-REQ -> all outputs 0 next cycle. tick_period=0 -> tick on every slow edge.
